// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file write-port controller.
// The top module takes its parameter defaults from here so the whole slice agrees on sizes.
package regfile_pkg;

    localparam int AW            = 5;
    localparam int DW            = 32;
    localparam int NREG          = 32;
    localparam int MAX_WAIT_DEF  = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Width of a counter that must be able to hold the value max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/regfile_wait_counter.sv
// Saturating count of consecutive cycles the external port was kept waiting.
// 'forced' goes high once the count reaches MAX_WAIT, letting the port through next.
module regfile_wait_counter
    import regfile_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic forced
);

    localparam int CW = cnt_width(MAX_WAIT);
    localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

    logic [CW-1:0] wcnt;

    // A handshake wins over a blocked cycle; once saturated the count just holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else if (clr) begin
            wcnt <= '0;
        end else if (inc && (wcnt != CMAX)) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    assign forced = (wcnt == CMAX);

endmodule

// File: rtl/regfile_write_ctrl.sv
// Single write port arbiter for the register file: zero-clears all registers after reset,
// then shares the port between core writeback (priority) and an external loader port.
module regfile_write_ctrl
    import regfile_pkg::*;
#(
    parameter int NREG           = regfile_pkg::NREG,
    parameter int AW             = regfile_pkg::AW,
    parameter int DW             = regfile_pkg::DW,
    parameter int MAX_WAIT       = MAX_WAIT_DEF,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_data,
    output logic          core_stall,
    input  logic          ext_valid,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_data,
    output logic          ext_ready,
    output logic [AW-1:0] A3,
    output logic [DW-1:0] WD3,
    output logic          WE,
    output logic          init_done
);

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] clr_idx;
    logic          done_q;
    logic          forced;
    wr_req_t       core_req, ext_req, grant;

    assign core_req = '{vld: core_we,   addr: core_addr, data: core_data};
    assign ext_req  = '{vld: ext_valid, addr: ext_addr,  data: ext_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_idx <= '0;
            done_q  <= (CLEAR_ON_RESET == 0);
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
                if (clr_idx == LAST_IDX)
                    done_q <= 1'b1;
            end
        end
    end

    // init_done must read low during reset even though the flop only clears at the edge.
    assign init_done = done_q & ~rst;

    always_comb begin
        state_nxt  = state;
        grant      = core_req;
        A3         = '0;
        WD3        = '0;
        WE         = 1'b0;
        core_stall = 1'b1;
        ext_ready  = 1'b0;
        if (!rst) begin
            unique case (state)
                CLEAR: begin
                    A3 = clr_idx;
                    WE = 1'b1;
                    if (clr_idx == LAST_IDX)
                        state_nxt = RUN;
                end
                RUN: begin
                    // ext_ready is offered independently of ext_valid: forced or core idle.
                    ext_ready  = forced | ~core_we;
                    core_stall = forced;
                    grant      = ext_ready ? ext_req : core_req;
                    A3         = grant.addr;
                    WD3        = grant.data;
                    WE         = grant.vld & (|grant.addr);
                end
                default: ;
            endcase
        end
    end

    regfile_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk    (clk),
        .rst    (rst),
        .clr    (ext_valid & ext_ready),
        .inc    (ext_valid & ~ext_ready),
        .forced (forced)
    );

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench: stimulus predicts port behaviour from a count-based model and queues it;
// a negedge monitor pops and compares. A bench-side register file records what DUT writes.
module tb_regfile_write_ctrl;

    localparam int NREG = 32;
    localparam int MAXW = 8;

    logic        clk = 1'b1;
    logic        rst = 1'b1;
    logic        core_we = 1'b0;
    logic [4:0]  core_addr = '0;
    logic [31:0] core_data = '0;
    logic        core_stall;
    logic        ext_valid = 1'b0;
    logic [4:0]  ext_addr = '0;
    logic [31:0] ext_data = '0;
    logic        ext_ready;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE;
    logic        init_done;

    regfile_write_ctrl #(
        .NREG(NREG), .AW(5), .DW(32), .MAX_WAIT(MAXW), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .core_we(core_we), .core_addr(core_addr), .core_data(core_data), .core_stall(core_stall),
        .ext_valid(ext_valid), .ext_addr(ext_addr), .ext_data(ext_data), .ext_ready(ext_ready),
        .A3(A3), .WD3(WD3), .WE(WE), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // The register file the DUT drives
    logic [31:0] rf [NREG];
    always @(posedge clk) if (WE) rf[A3] <= WD3;

    typedef struct {
        bit        we;
        bit [4:0]  a3;
        bit [31:0] wd3;
        bit        stall;
        bit        ready;
        bit        done;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state
    int          clear_left = 0;
    int          waited = 0;
    bit          done = 0;
    bit [31:0]   mrf [NREG];
    bit          last_stall = 1;
    bit          last_hs = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (WE !== e.we || core_stall !== e.stall || ext_ready !== e.ready ||
                init_done !== e.done || (e.we && (A3 !== e.a3 || WD3 !== e.wd3))) begin
                n_bad++;
                $display("FAIL port_cycle%0d: got we=%b a3=%0d wd3=%h stall=%b rdy=%b done=%b; want we=%b a3=%0d wd3=%h stall=%b rdy=%b done=%b",
                         cyc, WE, A3, WD3, core_stall, ext_ready, init_done,
                         e.we, e.a3, e.wd3, e.stall, e.ready, e.done);
            end
            cyc++;
        end
    end

    task automatic check_reg(input string name, input int idx, input bit [31:0] want);
        n_cmp++;
        if (rf[idx] !== want) begin
            n_bad++;
            $display("FAIL %s: reg%0d got %h want %h", name, idx, rf[idx], want);
        end
    endtask

    task automatic step(input bit r, input bit cwe, input bit [4:0] ca, input bit [31:0] cd,
                        input bit ev, input bit [4:0] ea, input bit [31:0] ed);
        exp_t e;
        bit   hs;
        rst = r; core_we = cwe; core_addr = ca; core_data = cd;
        ext_valid = ev; ext_addr = ea; ext_data = ed;
        e.we = 0; e.a3 = 0; e.wd3 = 0; e.stall = 1; e.ready = 0; e.done = 0;
        hs = 0;
        if (r) begin
            clear_left = NREG;
            waited = 0;
            done = 0;
        end else if (clear_left > 0) begin
            e.we = 1;
            e.a3 = 5'(NREG - clear_left);
            e.done = done;
            mrf[e.a3] = 0;
            if (ev && waited < MAXW) waited++;
            clear_left--;
            if (clear_left == 0) done = 1;
        end else begin
            e.stall = (waited == MAXW);
            e.ready = e.stall || !cwe;
            e.a3  = e.ready ? ea : ca;
            e.wd3 = e.ready ? ed : cd;
            e.we  = (e.ready ? ev : cwe) && (e.a3 != 0);
            e.done = done;
            hs = ev && e.ready;
            if (hs) waited = 0;
            else if (ev && waited < MAXW) waited++;
            if (e.we) mrf[e.a3] = e.wd3;
        end
        last_stall = e.stall;
        last_hs = hs;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : stim
        bit        cwe, ev;
        bit [4:0]  ca, ea;
        bit [31:0] cd, ed;
        #1;
        // Reset then the full zero-clear, then one RUN cycle
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (NREG) idle();
        idle();
        for (int i = 0; i < NREG; i++) check_reg("clear_zero", i, 32'h0);

        // Core write and idle-core external write
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        check_reg("core_write", 5, 32'hDEADBEEF);
        step(0, 0, 0, 0, 1, 5'd7, 32'h12345678);
        check_reg("ext_write", 7, 32'h12345678);

        // Starvation: ext blocked 8 cycles, forced on the 9th, core goes on the 10th
        for (int i = 0; i < 9; i++) step(0, 1, 5'd3, 32'h11, 1, 5'd9, 32'hA5A5A5A5);
        check_reg("starve_ext", 9, 32'hA5A5A5A5);
        step(0, 1, 5'd3, 32'h11, 0, 0, 0);
        check_reg("starve_core", 3, 32'h11);

        // $zero protection from both requesters
        step(0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5'd0, 32'hCAFEF00D);
        idle();
        check_reg("zero_protect", 0, 32'h0);

        // Reset in the middle of the clear sequence
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (10) idle();
        step(1, 0, 0, 0, 1, 5'd4, 32'h44);
        repeat (NREG) idle();
        idle();

        // Randomized traffic: core request held while stalled, ext held until accepted
        cwe = 0; ca = 0; cd = 0; ev = 0; ea = 0; ed = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall) begin
                cwe = ($urandom_range(0, 3) != 0);
                ca  = 5'($urandom_range(0, 31));
                cd  = $urandom;
            end
            if (!ev || last_hs) begin
                ev = ($urandom_range(0, 2) == 0);
                ea = 5'($urandom_range(0, 31));
                ed = $urandom;
            end
            step($urandom_range(0, 299) == 0, cwe, ca, cd, ev, ea, ed);
        end
        repeat (NREG + 2) idle();
        for (int i = 0; i < NREG; i++) check_reg("final_rf", i, mrf[i]);

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected cycles never compared, want 0", q.size());
        end
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
